// File: rtl/sgd_layer_update_if.sv
// sgd_layer_update_if: parameter load, gradient handshake and parameter outputs of one SGD layer stage
interface sgd_layer_update_if #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DATA_W     = 16,
  parameter int BATCH_LOG2 = 2
);
  logic                                   enable;
  logic                                   load;
  logic [ROWS-1:0][COLS-1:0][DATA_W-1:0] W_in;
  logic [ROWS-1:0][DATA_W-1:0]           b_in;
  logic                                   grad_valid;
  logic                                   grad_ready;
  logic [ROWS-1:0][COLS-1:0][DATA_W-1:0] dW;
  logic [ROWS-1:0][DATA_W-1:0]           db;
  logic [ROWS-1:0][COLS-1:0][DATA_W-1:0] W;
  logic [ROWS-1:0][DATA_W-1:0]           b;
  logic [BATCH_LOG2:0]                    sample_count;
  logic                                   update_done;
  modport master (
    output enable, load, W_in, b_in, grad_valid, dW, db,
    input  grad_ready, W, b, sample_count, update_done
  );
  modport slave (
    input  enable, load, W_in, b_in, grad_valid, dW, db,
    output grad_ready, W, b, sample_count, update_done
  );
endinterface

// File: rtl/sgd_layer_update.sv
// sgd_layer_update: mini-batch gradient accumulation and shift-based SGD row sweep; SGD_SATURATE_EN selects saturating narrowing
module sgd_layer_update #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DATA_W     = 16,
  parameter int FRAC_W     = 8,
  parameter int BATCH_LOG2 = 2,
  parameter int LR_SHIFT   = 4
) (
  input logic clk,
  input logic reset,
  sgd_layer_update_if.slave io
);
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam int SH = LR_SHIFT + BATCH_LOG2;
  localparam logic [BATCH_LOG2:0] LAST = (BATCH_LOG2+1)'((1 << BATCH_LOG2) - 1);
`ifdef SGD_SATURATE_EN
  localparam logic signed [2*DATA_W-1:0] S_MAX = {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [2*DATA_W-1:0] S_MIN = ~S_MAX;
`endif
  if (FRAC_W >= DATA_W || BATCH_LOG2 > 15) begin : g_bad_cfg
    $error("sgd_layer_update: FRAC_W must be below DATA_W and BATCH_LOG2 at most 15");
  end
  typedef enum logic [1:0] {ACCUM, UPDATE, DONE} state_t;
  state_t state, state_nxt;
  logic [RW-1:0] row;
  logic [BATCH_LOG2:0] count;
  logic [ROWS-1:0][COLS-1:0][DATA_W-1:0] w_q;
  logic [ROWS-1:0][DATA_W-1:0] b_q;
  logic signed [2*DATA_W-1:0] acc_w [ROWS][COLS];
  logic signed [2*DATA_W-1:0] acc_b [ROWS];
  logic [DATA_W-1:0] w_new [COLS];
  logic [DATA_W-1:0] b_new;
  function automatic logic signed [2*DATA_W-1:0] sext(input logic [DATA_W-1:0] v);
    return {{DATA_W{v[DATA_W-1]}}, v};
  endfunction
  function automatic logic [DATA_W-1:0] reduce(input logic signed [2*DATA_W-1:0] v);
`ifdef SGD_SATURATE_EN
    return v > S_MAX ? S_MAX[DATA_W-1:0] : v < S_MIN ? S_MIN[DATA_W-1:0] : v[DATA_W-1:0];
`else
    return v[DATA_W-1:0];
`endif
  endfunction
  assign io.grad_ready   = state == ACCUM;
  assign io.update_done  = state == DONE;
  assign io.W            = w_q;
  assign io.b            = b_q;
  assign io.sample_count = count;
  // state register; enable low freezes the FSM
  always_ff @(posedge clk)
    if (!reset) state <= ACCUM;
    else if (io.enable) state <= state_nxt;
  // next state: load aborts anything, last sample of a batch starts the sweep
  always_comb begin
    state_nxt = io.load ? ACCUM :
                state == ACCUM ? (io.grad_valid && count == LAST ? UPDATE : ACCUM) :
                state == UPDATE ? (row == RW'(ROWS-1) ? DONE : UPDATE) : ACCUM;
  end
  // SGD step for the row currently being swept
  always_comb begin
    for (int c = 0; c < COLS; c++) w_new[c] = reduce(sext(w_q[row][c]) - (acc_w[row][c] >>> SH));
    b_new = reduce(sext(b_q[row]) - (acc_b[row] >>> SH));
  end
  // parameters, accumulators, sample counter and sweep row
  always_ff @(posedge clk)
    if (!reset) begin
      w_q   <= '0;
      b_q   <= '0;
      count <= '0;
      row   <= '0;
      for (int r = 0; r < ROWS; r++) begin
        acc_b[r] <= '0;
        for (int c = 0; c < COLS; c++) acc_w[r][c] <= '0;
      end
    end else if (io.enable) begin
      if (io.load) begin
        w_q   <= io.W_in;
        b_q   <= io.b_in;
        count <= '0;
        row   <= '0;
        for (int r = 0; r < ROWS; r++) begin
          acc_b[r] <= '0;
          for (int c = 0; c < COLS; c++) acc_w[r][c] <= '0;
        end
      end else if (state == ACCUM && io.grad_valid) begin
        count <= count + 1'b1;
        row   <= '0;
        for (int r = 0; r < ROWS; r++) begin
          acc_b[r] <= acc_b[r] + sext(io.db[r]);
          for (int c = 0; c < COLS; c++) acc_w[r][c] <= acc_w[r][c] + sext(io.dW[r][c]);
        end
      end else if (state == UPDATE) begin
        for (int r = 0; r < ROWS; r++)
          if (RW'(r) == row) begin
            b_q[r]   <= b_new;
            acc_b[r] <= '0;
            for (int c = 0; c < COLS; c++) begin
              w_q[r][c]   <= w_new[c];
              acc_w[r][c] <= '0;
            end
          end
        row <= row + 1'b1;
      end else if (state == DONE) begin
        count <= '0;
        row   <= '0;
      end
    end
endmodule

// File: tb/tb_sgd_layer_update.sv
// tb_sgd_layer_update: directed vectors for accumulate, sweep, backpressure, saturation, abort and stall
module tb_sgd_layer_update;
  localparam int R  = 2;
  localparam int C  = 3;
  localparam int DW = 16;
  localparam int BL = 1;
  localparam int LS = 2;
`ifdef SGD_SATURATE_EN
  localparam logic [15:0] EXP_SAT = 16'h7FFF;
`else
  localparam logic [15:0] EXP_SAT = 16'h8FF0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  int vecs = 0;
  int errs = 0;
  always #5 clk = ~clk;
  sgd_layer_update_if #(.ROWS(R), .COLS(C), .DATA_W(DW), .BATCH_LOG2(BL)) io ();
  sgd_layer_update #(.ROWS(R), .COLS(C), .DATA_W(DW), .FRAC_W(8), .BATCH_LOG2(BL), .LR_SHIFT(LS)) dut (
    .clk(clk),
    .reset(reset),
    .io(io.slave)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [15:0] dwv, input logic [15:0] dbv);
    io.grad_valid = v;
    for (int r = 0; r < R; r++) begin
      io.db[r] = dbv;
      for (int c = 0; c < C; c++) io.dW[r][c] = dwv;
    end
  endtask
  task automatic do_load(input logic [15:0] wv, input logic [15:0] bv);
    for (int r = 0; r < R; r++) begin
      io.b_in[r] = bv;
      for (int c = 0; c < C; c++) io.W_in[r][c] = wv;
    end
    io.load = 1'b1;
    step();
    io.load = 1'b0;
  endtask
  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    for (int r = 0; r < R; r++) begin
      vecs++;
      if (io.b[r] !== 16'h0000) begin errs++; $display("FAIL reset_b[%0d] got %h exp 0000", r, io.b[r]); end
      for (int c = 0; c < C; c++) begin
        vecs++;
        if (io.W[r][c] !== 16'h0000) begin errs++; $display("FAIL reset_W[%0d][%0d] got %h exp 0000", r, c, io.W[r][c]); end
      end
    end
    vecs++;
    if (io.grad_ready !== 1'b1) begin errs++; $display("FAIL reset_ready got %b exp 1", io.grad_ready); end
    vecs++;
    if (io.update_done !== 1'b0) begin errs++; $display("FAIL reset_done got %b exp 0", io.update_done); end
    vecs++;
    if (io.sample_count !== 2'd0) begin errs++; $display("FAIL reset_count got %0d exp 0", io.sample_count); end
    reset = 1'b1;
    step();
  endtask
  task automatic test_basic_update();
    do_load(16'h0100, 16'h0000);
    drive(1'b1, 16'h0040, 16'h0020);
    step();
    vecs++;
    if (io.sample_count !== 2'd1) begin errs++; $display("FAIL basic_count1 got %0d exp 1", io.sample_count); end
    step();
    drive(1'b0, 16'h0000, 16'h0000);
    vecs++;
    if (io.sample_count !== 2'd2) begin errs++; $display("FAIL basic_count2 got %0d exp 2", io.sample_count); end
    vecs++;
    if (io.grad_ready !== 1'b0) begin errs++; $display("FAIL basic_ready_upd got %b exp 0", io.grad_ready); end
    step();
    for (int c = 0; c < C; c++) begin
      vecs++;
      if (io.W[0][c] !== 16'h00F0) begin errs++; $display("FAIL basic_row0_W[%0d] got %h exp 00F0", c, io.W[0][c]); end
      vecs++;
      if (io.W[1][c] !== 16'h0100) begin errs++; $display("FAIL basic_row1_old_W[%0d] got %h exp 0100", c, io.W[1][c]); end
    end
    vecs++;
    if (io.b[0] !== 16'hFFF8 || io.b[1] !== 16'h0000) begin errs++; $display("FAIL basic_b_mid got %h %h exp FFF8 0000", io.b[0], io.b[1]); end
    vecs++;
    if (io.update_done !== 1'b0) begin errs++; $display("FAIL basic_done_early got %b exp 0", io.update_done); end
    step();
    for (int r = 0; r < R; r++) begin
      vecs++;
      if (io.b[r] !== 16'hFFF8) begin errs++; $display("FAIL basic_b[%0d] got %h exp FFF8", r, io.b[r]); end
      for (int c = 0; c < C; c++) begin
        vecs++;
        if (io.W[r][c] !== 16'h00F0) begin errs++; $display("FAIL basic_W[%0d][%0d] got %h exp 00F0", r, c, io.W[r][c]); end
      end
    end
    vecs++;
    if (io.update_done !== 1'b1 || io.grad_ready !== 1'b0) begin errs++; $display("FAIL basic_done got done=%b ready=%b exp 1 0", io.update_done, io.grad_ready); end
    step();
    vecs++;
    if (io.update_done !== 1'b0 || io.grad_ready !== 1'b1 || io.sample_count !== 2'd0) begin
      errs++; $display("FAIL basic_after got done=%b ready=%b count=%0d exp 0 1 0", io.update_done, io.grad_ready, io.sample_count);
    end
  endtask
  task automatic test_backpressure();
    logic [15:0] dwv [9] = '{16'h0040, 16'h0040, 16'h7000, 16'h7000, 16'h7000, 16'h0080, 16'h0080, 16'h7000, 16'h7000};
    logic [15:0] dbv [9] = '{16'h0020, 16'h0020, 16'h3000, 16'h3000, 16'h3000, 16'h0040, 16'h0040, 16'h3000, 16'h3000};
    logic        rdy [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        dne [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [1:0]  cnt [9] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd0, 2'd1, 2'd2, 2'd2, 2'd2};
    do_load(16'h0100, 16'h0000);
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, dwv[i], dbv[i]);
      step();
      vecs++;
      if (io.grad_ready !== rdy[i] || io.update_done !== dne[i] || io.sample_count !== cnt[i]) begin
        errs++;
        $display("FAIL bp_cycle%0d got ready=%b done=%b count=%0d exp %b %b %0d", i, io.grad_ready, io.update_done, io.sample_count, rdy[i], dne[i], cnt[i]);
      end
    end
    drive(1'b0, 16'h0000, 16'h0000);
    for (int r = 0; r < R; r++) begin
      vecs++;
      if (io.b[r] !== 16'hFFE8) begin errs++; $display("FAIL bp_b[%0d] got %h exp FFE8", r, io.b[r]); end
      for (int c = 0; c < C; c++) begin
        vecs++;
        if (io.W[r][c] !== 16'h00D0) begin errs++; $display("FAIL bp_W[%0d][%0d] got %h exp 00D0", r, c, io.W[r][c]); end
      end
    end
    step();
  endtask
  task automatic test_saturation();
    do_load(16'h7FF0, 16'h0000);
    drive(1'b1, 16'hC000, 16'h0000);
    step();
    step();
    drive(1'b0, 16'h0000, 16'h0000);
    step();
    step();
    vecs++;
    if (io.update_done !== 1'b1) begin errs++; $display("FAIL sat_done got %b exp 1", io.update_done); end
    for (int r = 0; r < R; r++) begin
      vecs++;
      if (io.b[r] !== 16'h0000) begin errs++; $display("FAIL sat_b[%0d] got %h exp 0000", r, io.b[r]); end
      for (int c = 0; c < C; c++) begin
        vecs++;
        if (io.W[r][c] !== EXP_SAT) begin errs++; $display("FAIL sat_W[%0d][%0d] got %h exp %h", r, c, io.W[r][c], EXP_SAT); end
      end
    end
    step();
  endtask
  task automatic test_abort();
    do_load(16'h0100, 16'h0000);
    drive(1'b1, 16'h0040, 16'h0020);
    step();
    step();
    drive(1'b0, 16'h0000, 16'h0000);
    step();
    vecs++;
    if (io.W[0][0] !== 16'h00F0 || io.W[1][0] !== 16'h0100) begin errs++; $display("FAIL abort_mid got %h %h exp 00F0 0100", io.W[0][0], io.W[1][0]); end
    do_load(16'h0200, 16'h0200);
    for (int r = 0; r < R; r++) begin
      vecs++;
      if (io.b[r] !== 16'h0200) begin errs++; $display("FAIL abort_b[%0d] got %h exp 0200", r, io.b[r]); end
      for (int c = 0; c < C; c++) begin
        vecs++;
        if (io.W[r][c] !== 16'h0200) begin errs++; $display("FAIL abort_W[%0d][%0d] got %h exp 0200", r, c, io.W[r][c]); end
      end
    end
    vecs++;
    if (io.sample_count !== 2'd0 || io.grad_ready !== 1'b1 || io.update_done !== 1'b0) begin
      errs++; $display("FAIL abort_state got count=%0d ready=%b done=%b exp 0 1 0", io.sample_count, io.grad_ready, io.update_done);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      vecs++;
      if (io.update_done !== 1'b0) begin errs++; $display("FAIL abort_no_done%0d got %b exp 0", i, io.update_done); end
    end
    drive(1'b1, 16'h0040, 16'h0020);
    step();
    step();
    drive(1'b0, 16'h0000, 16'h0000);
    step();
    step();
    vecs++;
    if (io.W[0][0] !== 16'h01F0 || io.W[1][2] !== 16'h01F0 || io.b[1] !== 16'h01F8 || io.update_done !== 1'b1) begin
      errs++; $display("FAIL abort_next_batch got W=%h %h b=%h done=%b exp 01F0 01F0 01F8 1", io.W[0][0], io.W[1][2], io.b[1], io.update_done);
    end
    step();
    do_load(16'h0100, 16'h0000);
    drive(1'b1, 16'h0040, 16'h0020);
    step();
    step();
    drive(1'b0, 16'h0000, 16'h0000);
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    vecs++;
    if (io.W[0][0] !== 16'h0000 || io.W[1][1] !== 16'h0000 || io.b[0] !== 16'h0000) begin
      errs++; $display("FAIL reset_mid_W got %h %h %h exp 0000", io.W[0][0], io.W[1][1], io.b[0]);
    end
    vecs++;
    if (io.grad_ready !== 1'b1 || io.update_done !== 1'b0 || io.sample_count !== 2'd0) begin
      errs++; $display("FAIL reset_mid_state got ready=%b done=%b count=%0d exp 1 0 0", io.grad_ready, io.update_done, io.sample_count);
    end
    step();
  endtask
  task automatic test_enable_stall();
    do_load(16'h0100, 16'h0000);
    drive(1'b1, 16'h0040, 16'h0020);
    step();
    io.enable = 1'b0;
    drive(1'b1, 16'h7000, 16'h3000);
    for (int i = 0; i < 3; i++) begin
      step();
      vecs++;
      if (io.sample_count !== 2'd1 || io.grad_ready !== 1'b1) begin
        errs++; $display("FAIL stall_hold%0d got count=%0d ready=%b exp 1 1", i, io.sample_count, io.grad_ready);
      end
    end
    io.enable = 1'b1;
    drive(1'b1, 16'h0040, 16'h0020);
    step();
    drive(1'b0, 16'h0000, 16'h0000);
    vecs++;
    if (io.sample_count !== 2'd2) begin errs++; $display("FAIL stall_count got %0d exp 2", io.sample_count); end
    step();
    step();
    for (int r = 0; r < R; r++) begin
      vecs++;
      if (io.b[r] !== 16'hFFF8) begin errs++; $display("FAIL stall_b[%0d] got %h exp FFF8", r, io.b[r]); end
      for (int c = 0; c < C; c++) begin
        vecs++;
        if (io.W[r][c] !== 16'h00F0) begin errs++; $display("FAIL stall_W[%0d][%0d] got %h exp 00F0", r, c, io.W[r][c]); end
      end
    end
    vecs++;
    if (io.update_done !== 1'b1) begin errs++; $display("FAIL stall_done got %b exp 1", io.update_done); end
    io.enable = 1'b0;
    step();
    step();
    vecs++;
    if (io.update_done !== 1'b1) begin errs++; $display("FAIL stall_done_frozen got %b exp 1", io.update_done); end
    io.enable = 1'b1;
    step();
    vecs++;
    if (io.update_done !== 1'b0 || io.grad_ready !== 1'b1) begin
      errs++; $display("FAIL stall_release got done=%b ready=%b exp 0 1", io.update_done, io.grad_ready);
    end
  endtask
  initial begin
    io.enable = 1'b1;
    io.load   = 1'b0;
    io.W_in   = '0;
    io.b_in   = '0;
    drive(1'b0, 16'h0000, 16'h0000);
    test_reset();
    test_basic_update();
    test_backpressure();
    test_saturation();
    test_abort();
    test_enable_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/sgd_layer_update.md
# sgd_layer_update

Gradient-consuming stage placed directly downstream of the backward-propagation net, one instance per layer (W1/b1, W2/b2, W3/b3). It takes the per-sample gradients `dW`/`db` on each sample strobe and accumulates them over a mini-batch of `2**BATCH_LOG2` samples in double-width registers. It then applies a shift-based SGD step, `W <= W - (acc >>> (LR_SHIFT+BATCH_LOG2))`, sweeping one row per cycle. The updated `W`/`b` feed the forward net for the next batch.

## Interface
- `ROWS`, 4: output neurons (rows of W, length of b).
- `COLS`, 4: input neurons (columns of W).
- `DATA_W`, 16: width of `data_type`, signed fixed point.
- `FRAC_W`, 8: fractional bits of `data_type`. Informational only; the arithmetic is format-agnostic.
- `BATCH_LOG2`, 2: mini-batch size is `2**BATCH_LOG2`. Range 0..15.
- `LR_SHIFT`, 4: learning rate is `2**-LR_SHIFT`.

Ports:
- `clk`, in, 1: single clock.
- `reset`, in, 1: synchronous, active-low.
- `enable`, in, 1: global enable. When low, every register holds its value.
- `load`, in, 1: load initial parameters from `W_in`/`b_in`.
- `W_in`, in, `data_type[ROWS][COLS]`: initial weights.
- `b_in`, in, `data_type[ROWS][1]`: initial biases.
- `grad_valid`, in, 1: `dW`/`db` hold a sample. Driven by the backward net's sample strobe.
- `grad_ready`, out, 1: block can accept a sample.
- `dW`, in, `data_type[ROWS][COLS]`: per-sample weight gradient.
- `db`, in, `data_type[ROWS][1]`: per-sample bias gradient.
- `W`, out, `data_type[ROWS][COLS]`: current weights (registered).
- `b`, out, `data_type[ROWS][1]`: current biases (registered).
- `sample_count`, out, `BATCH_LOG2+1`: samples accepted in the current batch.
- `update_done`, out, 1: the batch update has completed.

## Operation
- **State machine:** `ACCUM`, `UPDATE`, `DONE`.
- **Reset** (`reset`=0 at a clk edge): state `ACCUM`, `W`=0, `b`=0, all accumulators 0, `sample_count`=0, row index 0.
  - Output values after reset: `grad_ready`=1, `update_done`=0.
- **Outputs:** `grad_ready` = (state==`ACCUM`); `update_done` = (state==`DONE`).
- **Accumulators:** `acc_W[ROWS][COLS]` and `acc_b[ROWS]`, each `2*DATA_W` signed. Every input is sign-extended before adding. The accumulators cannot overflow for `BATCH_LOG2`≤15.
- **Accept:** on `enable && grad_valid && grad_ready`:
  - `acc += dW`, `acc_b += db`, `sample_count++`.
  - If this was the `2**BATCH_LOG2`-th sample: state→`UPDATE`, row=0.
- **`UPDATE`** (one row r per enabled cycle):
  - delta = `acc >>> (LR_SHIFT+BATCH_LOG2)` (arithmetic shift, floor).
  - new = `W - delta`, computed at `2*DATA_W`, then reduced to `DATA_W` (see Configuration).
  - `W[r][*]`, `b[r]` take the new values; `acc_W[r][*]` and `acc_b[r]` clear to 0.
  - After r=`ROWS-1`: state→`DONE`.
- **`DONE`:** one enabled cycle, then state→`ACCUM` and `sample_count`←0.
- **`grad_valid` while not in `ACCUM`:** the sample is ignored (not buffered). Upstream must honour `grad_ready`.
- **`load`** (priority over everything except `reset`, accepted in any state when `enable`=1):
  - `W`←`W_in`, `b`←`b_in`; accumulators, `sample_count` and row index cleared; state→`ACCUM`.
  - A pending update is aborted and `update_done` is not asserted for it.
  - A simultaneous `grad_valid` is dropped.
- **`enable`=0:** FSM, accumulators and outputs freeze. If frozen in `DONE`, `update_done` stays high.

## Timing
- **Accumulate:** one sample per cycle max. The accumulator is updated at the accepting edge.
- **Update latency:** last sample accepted at edge t:
  - row r written at edge t+1+r;
  - `update_done` is high in the cycle after edge t+`ROWS`;
  - `grad_ready` is high again after edge t+`ROWS`+1.
- **Mid-sweep reads:** `W` is row-inconsistent during `UPDATE`. Consumers sample it only after `update_done`.
- **`load` / reset:** parameters are visible the cycle after the `load` edge. `reset` mid-`UPDATE` discards the partial sweep and zeros `W`.

## Configuration
- `SGD_SATURATE_EN` defined: the reduction to `DATA_W` saturates to [-2**(DATA_W-1), 2**(DATA_W-1)-1].
- `SGD_SATURATE_EN` undefined: the reduction keeps the low `DATA_W` bits (two's-complement wrap).

## Test plan
All scenarios use `ROWS`=2, `COLS`=3, `DATA_W`=16, `BATCH_LOG2`=1, `LR_SHIFT`=2.
- **Reset:** drive `reset`=0 for 2 cycles → `W`=0, `b`=0, `grad_ready`=1, `update_done`=0, `sample_count`=0.
- **Basic update:** `load` `W`=0x0100, `b`=0x0000; two samples `dW`=0x0040, `db`=0x0020 →
  - acc 0x0080 and 0x0040;
  - row0 updated on edge +1, row1 on edge +2: `W`=0x00F0, `b`=0xFFF8;
  - `update_done` high for exactly 1 cycle.
- **Backpressure:** hold `grad_valid`=1 with changing data throughout.
  - `grad_ready`=0 during `UPDATE`/`DONE` and those samples are not accumulated.
  - The next batch starts counting at 0 after `DONE`.
- **Saturation:** `W`=0x7FF0; two samples `dW`=0xC000 → delta=-0x1000.
  - With `SGD_SATURATE_EN`: `W`=0x7FFF.
  - Without: `W`=0x8FF0.
- **Abort:** assert `load` (`W_in`=0x0200) the cycle after row0 is written → `W`=0x0200 everywhere, `sample_count`=0, `grad_ready`=1, no `update_done`.
- **Enable stall:** drop `enable` for 3 cycles after the first sample of a batch → state, acc and `sample_count`=1 hold. The result is identical to the unstalled run.
